pulse_sync_rx: RTL and testbench
================================

PULSE_SYNC_RX -- requirements
Module: pulse_sync_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count, legal range 2..4.
REQ-002 SHALL have parameter MIN_WIDTH, default 2: consecutive synchronized-high cycles that qualify an event, legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 8: event counter width.
REQ-004 SHALL have port i_clk, input, 1: destination (receiving) clock.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_pulse_a, input, 1: stretched pulse from a foreign clock domain, asynchronous to i_clk.
REQ-007 SHALL have port i_cnt_clr, input, 1: synchronous event-counter clear.
REQ-008 SHALL have port o_pulse, output, 1: one-cycle pulse per qualified event.
REQ-009 SHALL have port o_level, output, 1: synchronized copy of i_pulse_a.
REQ-010 SHALL have port o_glitch, output, 1: one-cycle flag for a rejected short input.
REQ-011 SHALL have port o_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port o_evt_cnt, output, CNT_W: saturating count of qualified events.

Function
REQ-013 SHALL pass i_pulse_a through SYNC_STAGES flops clocked by i_clk; the last stage drives o_level; no logic SHALL sit between stages.
REQ-014 SHALL implement the FSM states IDLE, QUAL and HOLD, with a width counter wcnt.
REQ-015 IDLE transitions:
- o_level=1 and MIN_WIDTH=1: fire, go to HOLD.
- o_level=1 otherwise: set wcnt=1, go to QUAL.
REQ-016 QUAL transitions:
- o_level=1: increment wcnt; when the incremented value equals MIN_WIDTH, fire and go to HOLD.
- o_level=0: assert o_glitch for one cycle, go to IDLE, no fire.
REQ-017 HOLD SHALL go to IDLE on o_level=0; a re-rise SHALL therefore require a full falling edge, with no re-trigger while the level stays high.
REQ-018 "Fire" SHALL register o_pulse=1 for exactly one i_clk cycle.
REQ-019 Latency SHALL be SYNC_STAGES+MIN_WIDTH i_clk edges from the first edge sampling i_pulse_a high to o_pulse high.
REQ-020 o_evt_cnt SHALL increment on each fire and saturate at 2^CNT_W-1, with no wrap.
REQ-021 i_cnt_clr SHALL zero o_evt_cnt on the next edge; when clear and fire occur in the same cycle, clear SHALL win (result 0) while o_pulse still asserts.
REQ-022 Minimum input high time for reliable capture SHALL be (SYNC_STAGES... effectively MIN_WIDTH+1) i_clk periods; minimum low time between events SHALL be 2 i_clk periods.
REQ-023 o_pulse and o_glitch SHALL never be high in the same cycle.

Reset
REQ-024 While i_rst_n=0, all of the following SHALL be 0 asynchronously: synchronizer flops, wcnt, o_pulse, o_glitch, o_evt_cnt; the FSM SHALL be in IDLE.
REQ-025 Reset release SHALL be used synchronously; if i_pulse_a is high at release, it SHALL be treated as a new rising event after SYNC_STAGES+MIN_WIDTH cycles.
REQ-026 Reset asserted mid-QUAL or mid-HOLD SHALL discard the event, with no pulse and no glitch flag.

Configuration
REQ-027 Macro PULSE_SYNC_RX_CNT_EN:
- Defined: the event counter and i_cnt_clr are functional.
- Undefined: no counter flops exist, o_evt_cnt is tied to 0, and i_cnt_clr is ignored; all other behaviour is identical.

Structure
REQ-028 Package cdc_pkg SHALL hold the FSM state enum (IDLE/QUAL/HOLD) and the default constants for SYNC_STAGES and MIN_WIDTH.
REQ-029 The synchronizer chain SHALL be the sub-module cdc_sync_bit (parameter STAGES, ports i_clk, i_rst_n, i_d, o_q), so that the flops are identifiable for CDC constraints.

Verification
REQ-030 SYNC_STAGES=2, MIN_WIDTH=2, i_pulse_a high 5 cycles: o_pulse high exactly 1 cycle, at edge 4 after the first high sample; o_evt_cnt=1; o_glitch never high.
REQ-031 i_pulse_a high 1 cycle (MIN_WIDTH=2): o_glitch one cycle, no o_pulse, o_evt_cnt unchanged.
REQ-032 CNT_W=3, 9 valid events: o_evt_cnt reads 7 after the 7th and 8th and 9th events; then i_cnt_clr for 1 cycle gives 0.
REQ-033 i_cnt_clr asserted in the fire cycle: o_pulse=1, o_evt_cnt=0 on the next cycle.
REQ-034 i_rst_n pulsed low during QUAL: no o_pulse, no o_glitch, all outputs 0; with input still high after release, exactly one o_pulse follows after 4 cycles.
REQ-035 Build without PULSE_SYNC_RX_CNT_EN, 3 events: 3 o_pulse cycles, and o_evt_cnt stays 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the pulse receiver: FSM state encoding and
// default constants for the synchronizer depth and qualification width.
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HOLD = 2'd2
   } fsm_state_e;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int MIN_WIDTH_DEF   = 2;

   // Width counter is wide enough for the largest legal MIN_WIDTH (15).
   localparam int WCNT_W = 4;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer. Kept as its own module so the
// synchronizer flops can be located by name for CDC constraints.
// There is no logic between the stages.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_rx.sv
// Receiver for a stretched pulse from a foreign clock domain. The input is
// synchronized, then qualified by a minimum high width; a qualified event
// yields a one-cycle o_pulse, a too-short one a one-cycle o_glitch.
// Optional feature macro: PULSE_SYNC_RX_CNT_EN enables the saturating event
// counter and its clear input; without it o_evt_cnt is tied to zero.
module pulse_sync_rx
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int MIN_WIDTH   = MIN_WIDTH_DEF,
   parameter int CNT_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pulse_a,
   input  logic             i_cnt_clr,
   output logic             o_pulse,
   output logic             o_level,
   output logic             o_glitch,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_evt_cnt
);

   localparam logic [WCNT_W-1:0] MIN_W_L = WCNT_W'(MIN_WIDTH);
   localparam logic [WCNT_W-1:0] ONE_W_L = WCNT_W'(1);

   logic              level_s;
   fsm_state_e        state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [WCNT_W-1:0] wcnt_inc_s;
   logic              fire_s;
   logic              glitch_s;
   logic              pulse_q;
   logic              glitch_q;
   logic              busy_q;

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_pulse_a),
      .o_q     (level_s)
   );

   assign wcnt_inc_s = wcnt_q + ONE_W_L;

   // Next-state logic: qualify the synchronized level by its high width.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      fire_s   = 1'b0;
      glitch_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (level_s) begin
               if (MIN_W_L == ONE_W_L) begin
                  fire_s  = 1'b1;
                  wcnt_d  = '0;
                  state_d = HOLD;
               end else begin
                  wcnt_d  = ONE_W_L;
                  state_d = QUAL;
               end
            end else begin
               wcnt_d  = '0;
               state_d = IDLE;
            end
         end
         QUAL: begin
            if (level_s) begin
               wcnt_d = wcnt_inc_s;
               if (wcnt_inc_s == MIN_W_L) begin
                  fire_s  = 1'b1;
                  state_d = HOLD;
               end else begin
                  state_d = QUAL;
               end
            end else begin
               // Level dropped before qualifying: flag and discard.
               glitch_s = 1'b1;
               wcnt_d   = '0;
               state_d  = IDLE;
            end
         end
         HOLD: begin
            // Wait for a full falling edge before re-arming.
            if (!level_s) begin
               wcnt_d  = '0;
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            wcnt_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, width counter and registered event/status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         pulse_q  <= 1'b0;
         glitch_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         pulse_q  <= fire_s;
         glitch_q <= glitch_s;
         busy_q   <= (state_d != IDLE);
      end
   end

`ifdef PULSE_SYNC_RX_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating event count; a clear takes priority over a coincident fire.
   always_comb begin
      cnt_d = cnt_q;
      if (i_cnt_clr) begin
         cnt_d = '0;
      end else if (fire_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Event counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_evt_cnt = cnt_q;
`else
   logic unused_cnt_clr_s;
   assign unused_cnt_clr_s = i_cnt_clr;
   assign o_evt_cnt        = '0;
`endif

   assign o_pulse  = pulse_q;
   assign o_glitch = glitch_q;
   assign o_busy   = busy_q;
   assign o_level  = level_s;

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Scoreboard bench for pulse_sync_rx (SYNC_STAGES=2, MIN_WIDTH=2, CNT_W=3).
// Stimulus pushes the expected pulse/glitch (kind, edge number, count) into a
// queue; a negedge monitor pops and compares each time the DUT flags one.
module tb_pulse_sync_rx;

   localparam int SYNC = 2;
   localparam int MINW = 2;
   localparam int CW   = 3;
   localparam int LAT  = SYNC + MINW;
   localparam int CMAX = 7;

   typedef struct packed {
      logic is_pulse;
      int   cyc;
      int   cnt;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          pulse_a;
   logic          cnt_clr;
   logic          o_pulse;
   logic          o_level;
   logic          o_glitch;
   logic          o_busy;
   logic [CW-1:0] o_evt_cnt;

   int   cyc;
   int   vectors;
   int   miscompares;
   int   model_cnt;
   exp_t exp_q[$];

   pulse_sync_rx #(
      .SYNC_STAGES (SYNC),
      .MIN_WIDTH   (MINW),
      .CNT_W       (CW)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_pulse_a (pulse_a),
      .i_cnt_clr (cnt_clr),
      .o_pulse   (o_pulse),
      .o_level   (o_level),
      .o_glitch  (o_glitch),
      .o_busy    (o_busy),
      .o_evt_cnt (o_evt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors = vectors + 1;
      if (act != exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int next_cnt(input int c);
`ifdef PULSE_SYNC_RX_CNT_EN
      return (c < CMAX) ? c + 1 : CMAX;
`else
      return 0;
`endif
   endfunction

   task automatic push(input logic is_pulse, input int cnt);
      exp_t e;
      e.is_pulse = is_pulse;
      e.cyc      = cyc + LAT;
      e.cnt      = cnt;
      exp_q.push_back(e);
   endtask

   // One input pulse of hi cycles followed by lo low cycles.
   task automatic ev(input int hi, input int lo, input logic is_pulse);
      pulse_a = 1'b1;
      if (is_pulse) model_cnt = next_cnt(model_cnt);
      push(is_pulse, model_cnt);
      repeat (hi) @(negedge clk);
      pulse_a = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Monitor: every flagged cycle must match the head of the expected queue.
   always @(negedge clk) begin
      if (o_pulse || o_glitch) begin
         exp_t e;
         check("pulse_glitch_exclusive", int'(o_pulse & o_glitch), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_output", int'({o_pulse, o_glitch}), 0);
         end else begin
            e = exp_q.pop_front();
            check("kind_is_pulse", int'(o_pulse), int'(e.is_pulse));
            check("event_edge", cyc, e.cyc);
            check("evt_cnt_at_event", int'(o_evt_cnt), e.cnt);
         end
      end
   end

   initial begin
      cyc         = 0;
      vectors     = 0;
      miscompares = 0;
      model_cnt   = 0;
      rst_n       = 1'b0;
      pulse_a     = 1'b0;
      cnt_clr     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pulse", int'(o_pulse), 0);
      check("rst_glitch", int'(o_glitch), 0);
      check("rst_level", int'(o_level), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_cnt", int'(o_evt_cnt), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Qualified 5-cycle pulse, then idle afterwards
      ev(5, 4, 1'b1);
      check("idle_busy", int'(o_busy), 0);
      check("idle_level", int'(o_level), 0);

      // Single-cycle glitch
      ev(1, 4, 1'b0);
      check("glitch_busy", int'(o_busy), 0);
      check("glitch_cnt", int'(o_evt_cnt), model_cnt);

      // Eight more minimum-width events: count saturates at 7
      for (int i = 0; i < 8; i++) ev(MINW + 1, 3, 1'b1);
      check("sat_cnt", int'(o_evt_cnt), model_cnt);

      // Counter clear
      cnt_clr   = 1'b1;
      model_cnt = 0;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_cnt", int'(o_evt_cnt), 0);
      repeat (2) @(negedge clk);

      // Clear coincident with fire: pulse still asserts, count is 0
      pulse_a   = 1'b1;
      model_cnt = 0;
      push(1'b1, 0);
      repeat (LAT - 1) @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      @(negedge clk);
      pulse_a = 1'b0;
      repeat (4) @(negedge clk);
      ev(MINW + 1, 3, 1'b1);

      // Reset during QUAL discards the event; input still high afterwards
      pulse_a = 1'b1;
      repeat (3) @(negedge clk);
      check("qual_busy", int'(o_busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_pulse", int'(o_pulse), 0);
      check("midrst_glitch", int'(o_glitch), 0);
      check("midrst_level", int'(o_level), 0);
      check("midrst_busy", int'(o_busy), 0);
      check("midrst_cnt", int'(o_evt_cnt), 0);
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      model_cnt = next_cnt(0);
      push(1'b1, model_cnt);
      repeat (8) @(negedge clk);
      pulse_a = 1'b0;
      repeat (6) @(negedge clk);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
